// File: rtl/genius_pkg.sv
// Shared encodings for the genius sequence engine: FSM states, fail causes and LFSR constants.
package genius_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHOW_ON  = 3'd1,
      ST_SHOW_OFF = 3'd2,
      ST_WAIT_IN  = 3'd3,
      ST_ROUND_OK = 3'd4,
      ST_WIN      = 3'd5,
      ST_FAIL     = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_WRONG   = 2'b01,
      CAUSE_TIMEOUT = 2'b10,
      CAUSE_MULTI   = 2'b11
   } cause_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/genius_seq_mem.sv
// Sequence register file: one synchronous write port, one asynchronous read port.
module genius_seq_mem #(
   parameter int MAX_DEPTH = 16,
   parameter int ID_W      = 2,
   parameter int DEPTH_W   = 5
) (
   input  logic               clk,
   input  logic               we,
   input  logic [DEPTH_W-1:0] waddr,
   input  logic [ID_W-1:0]    wdata,
   input  logic [DEPTH_W-1:0] raddr,
   output logic [ID_W-1:0]    rdata
);

   localparam int AW = $clog2(MAX_DEPTH);

   logic [ID_W-1:0] mem_r [MAX_DEPTH];

   // Write port; out-of-range addresses are dropped rather than aliased.
   always_ff @(posedge clk) begin
      if (we && (waddr < DEPTH_W'(MAX_DEPTH))) begin
         mem_r[waddr[AW-1:0]] <= wdata;
      end
   end

   // Asynchronous read port.
   always_comb begin
      if (raddr < DEPTH_W'(MAX_DEPTH)) begin
         rdata = mem_r[raddr[AW-1:0]];
      end else begin
         rdata = {ID_W{1'b0}};
      end
   end

endmodule

// File: rtl/genius_seq_engine.sv
// Genius game sequence engine: playback, press checking, timeout and win/fail detection.
// Optional build macro GENIUS_LFSR_SEQ_EN fills the sequence from an internal LFSR.
module genius_seq_engine
   import genius_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int MAX_DEPTH     = 16,
   parameter int TIMEOUT_TICKS = 5,
   parameter int ID_W          = $clog2(N_CH),
   parameter int DEPTH_W       = $clog2(MAX_DEPTH + 1)
) (
   input  logic               CLOCK_50,
   input  logic               R,
   input  logic               start,
   input  logic [DEPTH_W-1:0] target_len,
   input  logic               seq_wr_en,
   input  logic [DEPTH_W-1:0] seq_wr_addr,
   input  logic [ID_W-1:0]    seq_wr_data,
   input  logic               tick,
   input  logic [N_CH-1:0]    btn,
   output logic [N_CH-1:0]    led,
   output logic [DEPTH_W-1:0] round,
   output logic [DEPTH_W-1:0] step,
   output logic [2:0]         state,
   output logic               match,
   output logic               win,
   output logic               fail,
   output logic [1:0]         fail_cause
);

   localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [N_CH-1:0] ZERO_CH = {N_CH{1'b0}};
   localparam logic [N_CH-1:0] ONE_CH  = {{(N_CH-1){1'b0}}, 1'b1};

   state_t             state_r, state_n_s;
   cause_t             cause_r, cause_n_s;
   logic [DEPTH_W-1:0] round_r, round_n_s, step_r, step_n_s, target_r, target_n_s;
   logic [CNT_W-1:0]   idle_r, idle_n_s, idle_inc_s;
   logic [N_CH-1:0]    led_r, led_n_s, ch_onehot_s;
   logic               match_r, match_n_s, win_r, win_n_s, fail_r, fail_n_s;
   logic               mem_we_s, last_s, multi_s;
   logic [DEPTH_W-1:0] mem_waddr_s, rd_addr_s;
   logic [ID_W-1:0]    mem_wdata_s, mem_rdata_s, ch_id_s;

`ifdef GENIUS_LFSR_SEQ_EN
   logic [15:0]     lfsr_r;
   logic [ID_W-1:0] lfsr_id_s;

   // Free-running sequence source, advancing every cycle.
   always_ff @(posedge CLOCK_50) begin
      if (!R) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= lfsr_next(lfsr_r);
      end
   end

   assign lfsr_id_s = ID_W'(lfsr_r % 16'(N_CH));

   // Generated elements: mem[0] at start, mem[round] when a new round opens.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = {DEPTH_W{1'b0}};
      mem_wdata_s = lfsr_id_s;
      if (start) begin
         mem_we_s = 1'b1;
      end else if ((state_r == ST_ROUND_OK) && tick) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = round_r;
      end else begin
         mem_we_s = 1'b0;
      end
   end
`else
   // External writes are only honoured while no game is in progress.
   always_comb begin
      mem_waddr_s = seq_wr_addr;
      mem_wdata_s = seq_wr_data;
      mem_we_s    = seq_wr_en && ((state_r == ST_IDLE) || (state_r == ST_WIN) ||
                                  (state_r == ST_FAIL));
   end
`endif

   // Read the element for the next displayed step, or the expected one while waiting.
   always_comb begin
      if (start || (state_r == ST_ROUND_OK)) begin
         rd_addr_s = {DEPTH_W{1'b0}};
      end else if (state_r == ST_SHOW_OFF) begin
         rd_addr_s = step_r + DEPTH_W'(1);
      end else begin
         rd_addr_s = step_r;
      end
   end

   genius_seq_mem #(
      .MAX_DEPTH (MAX_DEPTH),
      .ID_W      (ID_W),
      .DEPTH_W   (DEPTH_W)
   ) u_mem (
      .clk   (CLOCK_50),
      .we    (mem_we_s),
      .waddr (mem_waddr_s),
      .wdata (mem_wdata_s),
      .raddr (rd_addr_s),
      .rdata (mem_rdata_s)
   );

   // Forward a same-cycle write so the first shown LED never lags the stored element.
   assign ch_id_s     = (mem_we_s && (mem_waddr_s == rd_addr_s)) ? mem_wdata_s : mem_rdata_s;
   assign ch_onehot_s = ONE_CH << ch_id_s;
   assign last_s      = (step_r == (round_r - DEPTH_W'(1)));
   assign multi_s     = ((btn & (btn - ONE_CH)) != ZERO_CH);
   assign idle_inc_s  = idle_r + CNT_W'(1);

   // Next-state and next-output logic.
   always_comb begin
      state_n_s  = state_r;
      round_n_s  = round_r;
      step_n_s   = step_r;
      target_n_s = target_r;
      idle_n_s   = idle_r;
      win_n_s    = win_r;
      fail_n_s   = fail_r;
      cause_n_s  = cause_r;
      match_n_s  = 1'b0;
      if (start) begin
         if (target_len == {DEPTH_W{1'b0}}) begin
            target_n_s = DEPTH_W'(1);
         end else if (target_len > DEPTH_W'(MAX_DEPTH)) begin
            target_n_s = DEPTH_W'(MAX_DEPTH);
         end else begin
            target_n_s = target_len;
         end
         state_n_s = ST_SHOW_ON;
         round_n_s = DEPTH_W'(1);
         step_n_s  = {DEPTH_W{1'b0}};
         idle_n_s  = {CNT_W{1'b0}};
         win_n_s   = 1'b0;
         fail_n_s  = 1'b0;
         cause_n_s = CAUSE_NONE;
      end else begin
         case (state_r)
            ST_SHOW_ON: begin
               if (tick) begin
                  state_n_s = ST_SHOW_OFF;
               end else begin
                  state_n_s = ST_SHOW_ON;
               end
            end
            ST_SHOW_OFF: begin
               if (tick && last_s) begin
                  step_n_s  = {DEPTH_W{1'b0}};
                  idle_n_s  = {CNT_W{1'b0}};
                  state_n_s = ST_WAIT_IN;
               end else if (tick) begin
                  step_n_s  = step_r + DEPTH_W'(1);
                  state_n_s = ST_SHOW_ON;
               end else begin
                  state_n_s = ST_SHOW_OFF;
               end
            end
            ST_WAIT_IN: begin
               // A press always wins over a coincident tick.
               if (btn != ZERO_CH) begin
                  idle_n_s = {CNT_W{1'b0}};
                  if (multi_s) begin
                     fail_n_s  = 1'b1;
                     cause_n_s = CAUSE_MULTI;
                     state_n_s = ST_FAIL;
                  end else if (btn != ch_onehot_s) begin
                     fail_n_s  = 1'b1;
                     cause_n_s = CAUSE_WRONG;
                     state_n_s = ST_FAIL;
                  end else if (last_s && (round_r == target_r)) begin
                     match_n_s = 1'b1;
                     win_n_s   = 1'b1;
                     state_n_s = ST_WIN;
                  end else if (last_s) begin
                     match_n_s = 1'b1;
                     state_n_s = ST_ROUND_OK;
                  end else begin
                     step_n_s = step_r + DEPTH_W'(1);
                  end
               end else if (tick) begin
                  idle_n_s = idle_inc_s;
                  if (idle_inc_s == CNT_W'(TIMEOUT_TICKS)) begin
                     fail_n_s  = 1'b1;
                     cause_n_s = CAUSE_TIMEOUT;
                     state_n_s = ST_FAIL;
                  end else begin
                     state_n_s = ST_WAIT_IN;
                  end
               end else begin
                  state_n_s = ST_WAIT_IN;
               end
            end
            ST_ROUND_OK: begin
               if (tick) begin
                  round_n_s = round_r + DEPTH_W'(1);
                  step_n_s  = {DEPTH_W{1'b0}};
                  state_n_s = ST_SHOW_ON;
               end else begin
                  state_n_s = ST_ROUND_OK;
               end
            end
            ST_IDLE, ST_WIN, ST_FAIL: begin
               state_n_s = state_r;
            end
            default: begin
               state_n_s = ST_IDLE;
            end
         endcase
      end
      led_n_s = (state_n_s == ST_SHOW_ON) ? ch_onehot_s : ZERO_CH;
   end

   // Output and state registers with synchronous active-low reset.
   always_ff @(posedge CLOCK_50) begin
      if (!R) begin
         state_r  <= ST_IDLE;
         round_r  <= {DEPTH_W{1'b0}};
         step_r   <= {DEPTH_W{1'b0}};
         target_r <= DEPTH_W'(1);
         idle_r   <= {CNT_W{1'b0}};
         led_r    <= ZERO_CH;
         match_r  <= 1'b0;
         win_r    <= 1'b0;
         fail_r   <= 1'b0;
         cause_r  <= CAUSE_NONE;
      end else begin
         state_r  <= state_n_s;
         round_r  <= round_n_s;
         step_r   <= step_n_s;
         target_r <= target_n_s;
         idle_r   <= idle_n_s;
         led_r    <= led_n_s;
         match_r  <= match_n_s;
         win_r    <= win_n_s;
         fail_r   <= fail_n_s;
         cause_r  <= cause_n_s;
      end
   end

   assign state      = state_r;
   assign led        = led_r;
   assign round      = round_r;
   assign step       = step_r;
   assign match      = match_r;
   assign win        = win_r;
   assign fail       = fail_r;
   assign fail_cause = cause_r;

endmodule

// File: tb/tb_genius_seq_engine.sv
// Directed, table-driven bench for genius_seq_engine (default build, external sequence writes).
module tb_genius_seq_engine;

   localparam int N  = 4;
   localparam int DW = 5;
   localparam int IW = 2;

   logic          CLOCK_50 = 1'b0;
   logic          R = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] target_len = 5'd3;
   logic          seq_wr_en = 1'b0;
   logic [DW-1:0] seq_wr_addr = 5'd0;
   logic [IW-1:0] seq_wr_data = 2'd0;
   logic          tick = 1'b0;
   logic [N-1:0]  btn = 4'd0;
   logic [N-1:0]  led;
   logic [DW-1:0] round, step;
   logic [2:0]    state;
   logic          match, win, fail;
   logic [1:0]    fail_cause;

   int checks = 0;
   int errors = 0;

   genius_seq_engine dut (
      .CLOCK_50(CLOCK_50), .R(R), .start(start), .target_len(target_len),
      .seq_wr_en(seq_wr_en), .seq_wr_addr(seq_wr_addr), .seq_wr_data(seq_wr_data),
      .tick(tick), .btn(btn), .led(led), .round(round), .step(step), .state(state),
      .match(match), .win(win), .fail(fail), .fail_cause(fail_cause)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct packed {
      logic          st;
      logic          tk;
      logic [3:0]    b;
      logic [2:0]    e_state;
      logic [3:0]    e_led;
      logic [4:0]    e_round;
      logic [4:0]    e_step;
      logic          e_match;
      logic          e_win;
      logic          e_fail;
      logic [1:0]    e_cause;
   } vec_t;

   vec_t vecs [25];

   function automatic logic [21:0] exp_of(input logic [2:0] s, input logic [3:0] l,
                                          input logic [4:0] r, input logic [4:0] p,
                                          input logic m, input logic w, input logic f,
                                          input logic [1:0] c);
      return {s, l, r, p, m, w, f, c};
   endfunction

   function automatic logic [21:0] obs();
      return {state, led, round, step, match, win, fail, fail_cause};
   endfunction

   function automatic vec_t mk(input logic st, input logic tk, input logic [3:0] b,
                               input logic [2:0] s, input logic [3:0] l, input logic [4:0] r,
                               input logic [4:0] p, input logic m, input logic w);
      vec_t v;
      v = '{st, tk, b, s, l, r, p, m, w, 1'b0, 2'b00};
      return v;
   endfunction

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic go(input logic st, input logic tk, input logic [3:0] b);
      start = st; tick = tk; btn = b;
      cyc();
      start = 1'b0; tick = 1'b0; btn = 4'd0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) go(1'b0, 1'b1, 4'd0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [1:0] d);
      seq_wr_en = 1'b1; seq_wr_addr = a; seq_wr_data = d;
      cyc();
      seq_wr_en = 1'b0;
   endtask

   // obs fields: state led round step match win fail cause
   task automatic chk(input string nm, input logic [21:0] exp);
      checks++;
      if (obs() !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (state led round step match win fail cause)",
                  nm, obs(), exp);
      end
   endtask

   initial begin
      // Winning game with mem=[2,0,3,1], target 3.
      vecs[0]  = mk(1, 0, 4'h0, 3'd1, 4'h4, 5'd1, 5'd0, 0, 0);
      vecs[1]  = mk(0, 0, 4'h0, 3'd1, 4'h4, 5'd1, 5'd0, 0, 0);
      vecs[2]  = mk(0, 1, 4'h0, 3'd2, 4'h0, 5'd1, 5'd0, 0, 0);
      vecs[3]  = mk(0, 1, 4'h0, 3'd3, 4'h0, 5'd1, 5'd0, 0, 0);
      vecs[4]  = mk(0, 0, 4'h4, 3'd4, 4'h0, 5'd1, 5'd0, 1, 0);
      vecs[5]  = mk(0, 0, 4'h0, 3'd4, 4'h0, 5'd1, 5'd0, 0, 0);
      vecs[6]  = mk(0, 1, 4'h0, 3'd1, 4'h4, 5'd2, 5'd0, 0, 0);
      vecs[7]  = mk(0, 1, 4'h0, 3'd2, 4'h0, 5'd2, 5'd0, 0, 0);
      vecs[8]  = mk(0, 1, 4'h0, 3'd1, 4'h1, 5'd2, 5'd1, 0, 0);
      vecs[9]  = mk(0, 1, 4'h0, 3'd2, 4'h0, 5'd2, 5'd1, 0, 0);
      vecs[10] = mk(0, 1, 4'h0, 3'd3, 4'h0, 5'd2, 5'd0, 0, 0);
      vecs[11] = mk(0, 0, 4'h4, 3'd3, 4'h0, 5'd2, 5'd1, 0, 0);
      vecs[12] = mk(0, 0, 4'h1, 3'd4, 4'h0, 5'd2, 5'd1, 1, 0);
      vecs[13] = mk(0, 1, 4'h0, 3'd1, 4'h4, 5'd3, 5'd0, 0, 0);
      vecs[14] = mk(0, 1, 4'h0, 3'd2, 4'h0, 5'd3, 5'd0, 0, 0);
      vecs[15] = mk(0, 1, 4'h0, 3'd1, 4'h1, 5'd3, 5'd1, 0, 0);
      vecs[16] = mk(0, 1, 4'h0, 3'd2, 4'h0, 5'd3, 5'd1, 0, 0);
      vecs[17] = mk(0, 1, 4'h0, 3'd1, 4'h8, 5'd3, 5'd2, 0, 0);
      vecs[18] = mk(0, 1, 4'h0, 3'd2, 4'h0, 5'd3, 5'd2, 0, 0);
      vecs[19] = mk(0, 1, 4'h0, 3'd3, 4'h0, 5'd3, 5'd0, 0, 0);
      vecs[20] = mk(0, 0, 4'h4, 3'd3, 4'h0, 5'd3, 5'd1, 0, 0);
      vecs[21] = mk(0, 0, 4'h1, 3'd3, 4'h0, 5'd3, 5'd2, 0, 0);
      vecs[22] = mk(0, 0, 4'h8, 3'd5, 4'h0, 5'd3, 5'd2, 1, 1);
      vecs[23] = mk(0, 0, 4'h4, 3'd5, 4'h0, 5'd3, 5'd2, 0, 1);
      vecs[24] = mk(0, 1, 4'h0, 3'd5, 4'h0, 5'd3, 5'd2, 0, 1);

      // Reset.
      R = 1'b0;
      cyc(); cyc();
      R = 1'b1;
      chk("reset", exp_of(3'd0, 4'h0, 5'd0, 5'd0, 0, 0, 0, 2'b00));

      wr(5'd0, 2'd2); wr(5'd1, 2'd0); wr(5'd2, 2'd3); wr(5'd3, 2'd1);
      target_len = 5'd3;

      for (int i = 0; i < 25; i++) begin
         go(vecs[i].st, vecs[i].tk, vecs[i].b);
         chk($sformatf("vec%0d", i), {vecs[i].e_state, vecs[i].e_led, vecs[i].e_round,
             vecs[i].e_step, vecs[i].e_match, vecs[i].e_win, vecs[i].e_fail, vecs[i].e_cause});
      end

      // Wrong press at round 2, step 1, then restart.
      go(1, 0, 4'h0); ticks(2); go(0, 0, 4'h4); ticks(5);
      chk("r2_wait", exp_of(3'd3, 4'h0, 5'd2, 5'd0, 0, 0, 0, 2'b00));
      go(0, 0, 4'h4); go(0, 0, 4'h8);
      chk("wrong_press", exp_of(3'd6, 4'h0, 5'd2, 5'd1, 0, 0, 1, 2'b01));
      go(0, 1, 4'h4);
      chk("fail_hold", exp_of(3'd6, 4'h0, 5'd2, 5'd1, 0, 0, 1, 2'b01));
      go(1, 0, 4'h0);
      chk("restart", exp_of(3'd1, 4'h4, 5'd1, 5'd0, 0, 0, 0, 2'b00));

      // Timeout on the fifth idle tick.
      ticks(2); ticks(4);
      chk("idle4", exp_of(3'd3, 4'h0, 5'd1, 5'd0, 0, 0, 0, 2'b00));
      ticks(1);
      chk("timeout", exp_of(3'd6, 4'h0, 5'd1, 5'd0, 0, 0, 1, 2'b10));

      // Correct press coincident with the fifth tick clears the idle count.
      go(1, 0, 4'h0); ticks(2); go(0, 0, 4'h4); ticks(5); ticks(4);
      go(0, 1, 4'h4);
      chk("press_tick", exp_of(3'd3, 4'h0, 5'd2, 5'd1, 0, 0, 0, 2'b00));
      ticks(4);
      chk("idle_cleared", exp_of(3'd3, 4'h0, 5'd2, 5'd1, 0, 0, 0, 2'b00));
      ticks(1);
      chk("timeout2", exp_of(3'd6, 4'h0, 5'd2, 5'd1, 0, 0, 1, 2'b10));

      // Multi-press.
      go(1, 0, 4'h0); ticks(2); go(0, 0, 4'h3);
      chk("multi", exp_of(3'd6, 4'h0, 5'd1, 5'd0, 0, 0, 1, 2'b11));

      // Out-of-range write is dropped; write during play is ignored.
      wr(5'd16, 2'd1);
      go(1, 0, 4'h0);
      seq_wr_en = 1'b1; seq_wr_addr = 5'd0; seq_wr_data = 2'd1;
      go(0, 0, 4'h0);
      seq_wr_en = 1'b0;
      chk("wr_in_play", exp_of(3'd1, 4'h4, 5'd1, 5'd0, 0, 0, 0, 2'b00));
      ticks(2); go(0, 0, 4'h4); ticks(5); go(0, 0, 4'h4); go(0, 0, 4'h1); ticks(1);
      chk("r3_on", exp_of(3'd1, 4'h4, 5'd3, 5'd0, 0, 0, 0, 2'b00));
      ticks(1);
      chk("r3_off", exp_of(3'd2, 4'h0, 5'd3, 5'd0, 0, 0, 0, 2'b00));
      go(1, 0, 4'h0);
      chk("start_in_show", exp_of(3'd1, 4'h4, 5'd1, 5'd0, 0, 0, 0, 2'b00));

      // target_len 0 behaves as 1.
      target_len = 5'd0;
      go(1, 0, 4'h0); ticks(2); go(0, 0, 4'h4);
      chk("target0", exp_of(3'd5, 4'h0, 5'd1, 5'd0, 1, 1, 0, 2'b00));

      // Write accepted in WIN state changes the next playback.
      wr(5'd0, 2'd1);
      go(1, 0, 4'h0);
      chk("wr_in_win", exp_of(3'd1, 4'h2, 5'd1, 5'd0, 0, 0, 0, 2'b00));

      // Reset mid-game.
      ticks(1);
      R = 1'b0;
      cyc();
      chk("reset_mid", exp_of(3'd0, 4'h0, 5'd0, 5'd0, 0, 0, 0, 2'b00));
      R = 1'b1;
      cyc();
      chk("reset_hold", exp_of(3'd0, 4'h0, 5'd0, 5'd0, 0, 0, 0, 2'b00));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
